// File: rtl/fir_pkg.sv
// Shared constants, coefficient table, FSM encodings and arithmetic helpers for the FIR accelerator.
// The optional pipelined engine is built only when PIPE_ENGINE_EN is defined (see fir_accel_top).
package fir_pkg;

    localparam int NUM_TAPS         = 4;
    localparam int TAP_W            = 2;
    localparam int DEF_SAMPLE_COUNT = 100;
    localparam int DEF_INPUT_ADDR   = 0;
    localparam int DEF_OUTPUT_ADDR  = 512;
    localparam int MEM_ADDR_W       = 10;
    localparam int SAMPLE_W         = 8;
    localparam int ACC_W            = 18;
    localparam int SHIFT            = 7;

    localparam logic signed [ACC_W-1:0] COEFFS [NUM_TAPS] = '{18'sd16, 18'sd48, 18'sd48, 18'sd16};
    localparam logic signed [ACC_W-1:0] SAT_MAX = 18'sd127;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -18'sd128;

    typedef enum logic [3:0] {
        NP_IDLE    = 4'd0,
        NP_ADDR    = 4'd1,
        NP_CAPTURE = 4'd2,
        NP_SCALE   = 4'd3,
        NP_WRITE   = 4'd4,
        NP_NEXT    = 4'd5,
        NP_DONE    = 4'd6
    } np_state_t;

    typedef enum logic [2:0] {
        P_IDLE  = 3'd0,
        P_RUN   = 3'd1,
        P_DRAIN = 3'd2,
        P_DONE  = 3'd3
    } p_state_t;

    function automatic logic signed [ACC_W-1:0] tap_product(input logic [SAMPLE_W-1:0] sample,
                                                            input logic signed [ACC_W-1:0] coeff);
        logic signed [ACC_W-1:0] wide;
        wide = {{(ACC_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
        return wide * coeff;
    endfunction

    // Arithmetic shift floors toward minus infinity before clamping to the sample range.
    function automatic logic [SAMPLE_W-1:0] scale_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        shifted = acc >>> SHIFT;
        if (shifted > SAT_MAX) begin
            return SAT_MAX[SAMPLE_W-1:0];
        end
        if (shifted < SAT_MIN) begin
            return SAT_MIN[SAMPLE_W-1:0];
        end
        return shifted[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/fir_dpram.sv
// True dual-port sample RAM: independent synchronous write and registered read on ports A and B.
module fir_dpram
    import fir_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = SAMPLE_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              we_a,
    input  logic [DATA_W-1:0] data_in_a,
    output logic [DATA_W-1:0] data_out_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              we_b,
    input  logic [DATA_W-1:0] data_in_b,
    output logic [DATA_W-1:0] data_out_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= data_in_a;
        end
        if (we_b) begin
            mem[addr_b] <= data_in_b;
        end
        data_out_a <= mem[addr_a];
        data_out_b <= mem[addr_b];
    end

endmodule

// File: rtl/fir_accel_top.sv
// FIR accelerator: multi-cycle and (with PIPE_ENGINE_EN) pipelined engines filter the input region of
// an internal dual-port RAM into its output region; cycle_count measures each run.
module fir_accel_top
    import fir_pkg::*;
#(
    parameter int SAMPLE_COUNT = DEF_SAMPLE_COUNT,
    parameter int INPUT_ADDR   = DEF_INPUT_ADDR,
    parameter int OUTPUT_ADDR  = DEF_OUTPUT_ADDR,
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = SAMPLE_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sel_pipelined,
    output logic        done,
    output logic [31:0] cycle_count
);

    localparam logic [ADDR_W-1:0] IN_BASE  = ADDR_W'(INPUT_ADDR);
    localparam logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(OUTPUT_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SAMPLE_COUNT - 1);

    logic [ADDR_W-1:0] addr_a, addr_b;
    logic              we_b;
    logic [DATA_W-1:0] data_in_b, data_out_a, unused_dout_b;

    np_state_t non_pipe_state, non_pipe_state_next;
    p_state_t  pipe_state;

    logic        accept, launch_np, finish;
    logic        done_reg, run_active_reg;
    logic [31:0] count_reg;

    logic [ADDR_W-1:0] np_rd_addr, p_rd_addr, p_wr_addr;
    logic              p_we;
    logic [DATA_W-1:0] p_din;

    assign accept = start && (((non_pipe_state == NP_IDLE) && (pipe_state == P_IDLE)) || done_reg);
    assign finish = (non_pipe_state == NP_DONE) || (pipe_state == P_DONE);
    assign done        = done_reg;
    assign cycle_count = count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_reg       <= 1'b0;
            count_reg      <= '0;
            run_active_reg <= 1'b0;
        end else if (accept) begin
            done_reg       <= 1'b0;
            count_reg      <= '0;
            run_active_reg <= 1'b1;
        end else if (run_active_reg) begin
            count_reg <= count_reg + 32'd1;
            if (finish) begin
                done_reg       <= 1'b1;
                run_active_reg <= 1'b0;
            end
        end
    end

    // ---------------- non-pipelined engine ----------------
    logic [ADDR_W-1:0]       np_idx_reg;
    logic [TAP_W-1:0]        np_tap_reg;
    logic signed [ACC_W-1:0] np_acc_reg;
    logic [DATA_W-1:0]       np_result_reg;
    logic                    np_tap_valid;

    assign np_rd_addr   = IN_BASE + np_idx_reg - ADDR_W'(np_tap_reg);
    assign np_tap_valid = ADDR_W'(np_tap_reg) <= np_idx_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            non_pipe_state <= NP_IDLE;
        end else begin
            non_pipe_state <= non_pipe_state_next;
        end
    end

    // NP_NEXT is a single wind-down cycle after the final write, before DONE raises done.
    always_comb begin
        non_pipe_state_next = non_pipe_state;
        case (non_pipe_state)
            NP_IDLE:    if (launch_np) non_pipe_state_next = NP_ADDR;
            NP_ADDR:    non_pipe_state_next = NP_CAPTURE;
            NP_CAPTURE: non_pipe_state_next = (np_tap_reg == TAP_W'(NUM_TAPS - 1)) ? NP_SCALE : NP_ADDR;
            NP_SCALE:   non_pipe_state_next = NP_WRITE;
            NP_WRITE:   non_pipe_state_next = (np_idx_reg == LAST_IDX) ? NP_NEXT : NP_ADDR;
            NP_NEXT:    non_pipe_state_next = NP_DONE;
            NP_DONE:    non_pipe_state_next = NP_IDLE;
            default:    non_pipe_state_next = NP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            np_idx_reg    <= '0;
            np_tap_reg    <= '0;
            np_acc_reg    <= '0;
            np_result_reg <= '0;
        end else begin
            case (non_pipe_state)
                NP_IDLE: begin
                    if (launch_np) begin
                        np_idx_reg <= '0;
                        np_tap_reg <= '0;
                        np_acc_reg <= '0;
                    end
                end
                NP_CAPTURE: begin
                    if (np_tap_valid) begin
                        np_acc_reg <= np_acc_reg + tap_product(data_out_a, COEFFS[np_tap_reg]);
                    end
                    np_tap_reg <= np_tap_reg + 1'b1;
                end
                NP_SCALE: np_result_reg <= scale_sat(np_acc_reg);
                NP_WRITE: begin
                    np_idx_reg <= np_idx_reg + 1'b1;
                    np_acc_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    // ---------------- pipelined engine ----------------
`ifdef PIPE_ENGINE_EN
    p_state_t                pipe_state_next;
    logic                    launch_p, p_issue;
    logic [ADDR_W-1:0]       p_issue_idx_reg, p_wr_idx_reg;
    logic                    p_s1_valid_reg, p_s2_valid_reg;
    logic [DATA_W-1:0]       p_hist_reg [NUM_TAPS-1];
    logic [DATA_W-1:0]       p_window [NUM_TAPS];
    logic [DATA_W-1:0]       p_mac_reg;
    logic signed [ACC_W-1:0] p_sum;

    assign launch_np = accept && !sel_pipelined;
    assign launch_p  = accept && sel_pipelined;
    assign p_issue   = (pipe_state == P_RUN);
    assign p_rd_addr = IN_BASE + p_issue_idx_reg;
    assign p_wr_addr = OUT_BASE + p_wr_idx_reg;
    assign p_we      = p_s2_valid_reg;
    assign p_din     = p_mac_reg;

    // Window: the sample just read, then the three older samples from history.
    assign p_window[0] = data_out_a;
    for (genvar gi = 1; gi < NUM_TAPS; gi++) begin : g_window
        assign p_window[gi] = p_hist_reg[gi-1];
    end

    always_comb begin
        p_sum = '0;
        for (int t = 0; t < NUM_TAPS; t++) begin
            p_sum = p_sum + tap_product(p_window[t], COEFFS[t]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_state <= P_IDLE;
        end else begin
            pipe_state <= pipe_state_next;
        end
    end

    always_comb begin
        pipe_state_next = pipe_state;
        case (pipe_state)
            P_IDLE:  if (launch_p) pipe_state_next = P_RUN;
            P_RUN:   if (p_issue_idx_reg == LAST_IDX) pipe_state_next = P_DRAIN;
            P_DRAIN: if (!p_s1_valid_reg && !p_s2_valid_reg) pipe_state_next = P_DONE;
            P_DONE:  pipe_state_next = P_IDLE;
            default: pipe_state_next = P_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_issue_idx_reg <= '0;
            p_wr_idx_reg    <= '0;
            p_s1_valid_reg  <= 1'b0;
            p_s2_valid_reg  <= 1'b0;
            p_mac_reg       <= '0;
            for (int i = 0; i < NUM_TAPS - 1; i++) p_hist_reg[i] <= '0;
        end else begin
            p_s1_valid_reg <= p_issue;
            p_s2_valid_reg <= p_s1_valid_reg;
            if (launch_p) begin
                p_issue_idx_reg <= '0;
                p_wr_idx_reg    <= '0;
                for (int i = 0; i < NUM_TAPS - 1; i++) p_hist_reg[i] <= '0;
            end else begin
                if (p_issue) p_issue_idx_reg <= p_issue_idx_reg + 1'b1;
                if (p_s2_valid_reg) p_wr_idx_reg <= p_wr_idx_reg + 1'b1;
                if (p_s1_valid_reg) begin
                    p_mac_reg     <= scale_sat(p_sum);
                    p_hist_reg[0] <= data_out_a;
                    for (int i = 1; i < NUM_TAPS - 1; i++) p_hist_reg[i] <= p_hist_reg[i-1];
                end
            end
        end
    end
`else
    logic unused_sel;
    assign unused_sel = sel_pipelined;
    assign launch_np  = accept;
    assign pipe_state = P_IDLE;
    assign p_rd_addr  = '0;
    assign p_wr_addr  = '0;
    assign p_we       = 1'b0;
    assign p_din      = '0;
`endif

    // Engines only read on port A; its write side stays free for external loading.
    assign addr_a    = (non_pipe_state != NP_IDLE) ? np_rd_addr : p_rd_addr;
    assign we_b      = (non_pipe_state == NP_WRITE) || p_we;
    assign addr_b    = p_we ? p_wr_addr : (OUT_BASE + np_idx_reg);
    assign data_in_b = p_we ? p_din : np_result_reg;

    fir_dpram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) memory (
        .clk        (clk),
        .addr_a     (addr_a),
        .we_a       (1'b0),
        .data_in_a  ('0),
        .data_out_a (data_out_a),
        .addr_b     (addr_b),
        .we_b       (we_b),
        .data_in_b  (data_in_b),
        .data_out_b (unused_dout_b)
    );

endmodule

// File: tb/tb_fir_accel_top.sv
// Scoreboard bench for fir_accel_top: stimulus pushes expected cycle counts and output vectors,
// a monitor pops and compares on each rising done.
module tb_fir_accel_top;

    localparam int N         = 100;
    localparam int OUT_BASE  = 512;
    localparam int NP_CYCLES = 1002;
`ifdef PIPE_ENGINE_EN
    localparam int P_CYCLES  = 104;
`else
    localparam int P_CYCLES  = 1002;
`endif

    typedef struct packed {
        logic [31:0]           cycles;
        logic [N-1:0][7:0]     data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic        done;
    logic [31:0] cycle_count;

    int   total = 0;
    int   bad = 0;
    int   txn = 0;
    exp_t exp_q[$];
    exp_t cur;
    logic [7:0] xin [N];

    fir_accel_top dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .sel_pipelined (sel),
        .done          (done),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic fill_x(input int lo, input int hi, input int v);
        for (int i = lo; i <= hi; i++) begin
            xin[i] = 8'(v);
            dut.memory.mem[i] = 8'(v);
        end
    endtask

    task automatic fill_y(input int lo, input int hi, input int v);
        for (int i = lo; i <= hi; i++) cur.data[i] = 8'(v);
    endtask

    function automatic int ref_y(input int n);
        int acc;
        int c [4];
        c = '{16, 48, 48, 16};
        acc = 0;
        for (int t = 0; t < 4; t++) begin
            if (n - t >= 0) acc += c[t] * int'($signed(xin[n-t]));
        end
        acc = acc >>> 7;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        return acc;
    endfunction

    task automatic wait_sb(input int limit);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL done_timeout actual=pending required=done within %0d cycles", limit);
            exp_q.delete();
        end
    endtask

    task automatic prep_outputs();
        for (int i = 0; i < N; i++) dut.memory.mem[OUT_BASE+i] = 8'hA5;
    endtask

    task automatic run(input logic use_pipe, input int cyc);
        prep_outputs();
        cur.cycles = 32'(cyc);
        exp_q.push_back(cur);
        @(negedge clk);
        sel   = use_pipe;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_sb(3000);
        repeat (3) @(negedge clk);
        check("done_hold", int'(done), 1);
        check("count_hold", int'(cycle_count), cyc);
    endtask

    // Monitor: compares on each rising edge of done.
    initial begin : monitor
        logic done_seen;
        exp_t e;
        done_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && !done_seen) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual=done required=no run pending");
                end else begin
                    e = exp_q.pop_front();
                    txn++;
                    $display("txn %0d: done cycle_count=%0d expected=%0d", txn, cycle_count, e.cycles);
                    check("cycle_count", int'(cycle_count), int'(e.cycles));
                    for (int i = 0; i < N; i++) begin
                        check($sformatf("y[%0d]", i), int'($signed(dut.memory.mem[OUT_BASE+i])),
                              int'($signed(e.data[i])));
                    end
                end
            end
            done_seen = (done === 1'b1);
        end
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        check("rst_done", int'(done), 0);
        check("rst_count", int'(cycle_count), 0);
        check("rst_np_state", int'(dut.non_pipe_state), 0);
        check("rst_p_state", int'(dut.pipe_state), 0);
        rst = 1'b1;
        @(negedge clk);

        // Impulse of 64 on both engines.
        fill_x(0, N-1, 0);
        fill_x(0, 0, 64);
        fill_y(0, N-1, 0);
        fill_y(0, 0, 8); fill_y(1, 2, 24); fill_y(3, 3, 8);
        run(1'b0, NP_CYCLES);
        run(1'b1, P_CYCLES);

        // Step of 40, then the tail switched to -40.
        fill_x(0, N-1, 40);
        fill_y(0, 0, 5); fill_y(1, 1, 20); fill_y(2, 2, 35); fill_y(3, N-1, 40);
        run(1'b0, NP_CYCLES);
        fill_x(50, N-1, -40);
        fill_y(50, 50, 30); fill_y(51, 51, 0); fill_y(52, 52, -30); fill_y(53, N-1, -40);
        run(1'b1, P_CYCLES);

        // Floor on negatives, inexact positives, and the full-scale extremes.
        fill_x(0, N-1, 0);
        fill_x(0, 0, -1);
        fill_x(20, 30, 127);
        fill_x(40, N-1, -128);
        fill_y(0, N-1, 0);
        fill_y(0, 3, -1);
        fill_y(20, 20, 15); fill_y(21, 21, 63); fill_y(22, 22, 111); fill_y(23, 30, 127);
        fill_y(31, 31, 111); fill_y(32, 32, 63); fill_y(33, 33, 15);
        fill_y(40, 40, -16); fill_y(41, 41, -64); fill_y(42, 42, -112); fill_y(43, N-1, -128);
        run(1'b0, NP_CYCLES);
        run(1'b1, P_CYCLES);

        // Sine preload checked against the reference formula on both engines.
        for (int i = 0; i < N; i++) begin
            fill_x(i, i, $rtoi(64.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 40.0)));
        end
        for (int i = 0; i < N; i++) fill_y(i, i, ref_y(i));
        run(1'b0, NP_CYCLES);
        run(1'b1, P_CYCLES);

        // start and sel_pipelined toggled mid-run must not disturb the non-pipelined run.
        prep_outputs();
        cur.cycles = 32'(NP_CYCLES);
        exp_q.push_back(cur);
        @(negedge clk); sel = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (50) @(negedge clk);
        sel = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_sb(3000);

        // Reset mid-run aborts; a fresh start then completes normally.
        @(negedge clk); sel = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (298) @(negedge clk);
        check("busy_before_reset", int'(done), 0);
        rst = 1'b0;
        #1;
        check("abort_done", int'(done), 0);
        check("abort_count", int'(cycle_count), 0);
        check("abort_np_state", int'(dut.non_pipe_state), 0);
        check("abort_p_state", int'(dut.pipe_state), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run(1'b0, NP_CYCLES);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
